// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order completion tracker for the out-of-order core.
//  * Dispatch allocates one entry per instruction at the tail. The returned
//    address (alloc_rob_addr) travels with the instruction to execution.
//  * Writeback marks entries done.
//  * Entries retire in program order from the head. Each retirement hands the
//    previous physical destination mapping back to the free list.
//  * A branch mispredict restores the tail to a checkpoint and flushes every
//    younger entry.
//
// Parameters
//   DEPTH : number of entries (power of two, >= 4)
//   D_REG : physical data-register count (sets the register address width)
//
// Ports
//   clk, n_rst                      clock; synchronous active-low reset
//   alloc_valid/_write_dst/_prev_addr
//                                   dispatch request and payload
//   alloc_ready, alloc_rob_addr     entry available; granted address (= tail)
//   complete_valid/_rob_addr        writeback completion
//   restore, restore_tail           mispredict rollback to a checkpointed tail
//   retire_valid/_ready             head entry complete / free list accepts it
//   retire_write_dst/_prev_addr     payload of the head entry
//   rob_head, rob_tail              oldest entry / next entry to allocate
//   count, full, empty              occupancy 0..DEPTH and its flags
//
// Optional feature (macro ROB_STATS_EN)
//   Adds retired_cnt[31:0] (retirements) and full_stall_cnt[31:0] (cycles with
//   alloc_valid while full). Both wrap, clear on reset and survive restore.
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int D_REG = 64,
   localparam int AW = $clog2(DEPTH),
   localparam int RW = $clog2(D_REG),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          alloc_valid,
   input  logic          alloc_write_dst,
   input  logic [RW-1:0] alloc_prev_addr,
   output logic          alloc_ready,
   output logic [AW-1:0] alloc_rob_addr,
   input  logic          complete_valid,
   input  logic [AW-1:0] complete_rob_addr,
   input  logic          restore,
   input  logic [AW-1:0] restore_tail,
   output logic          retire_valid,
   input  logic          retire_ready,
   output logic          retire_write_dst,
   output logic [RW-1:0] retire_prev_addr,
   output logic [AW-1:0] rob_head,
   output logic [AW-1:0] rob_tail,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
`ifdef ROB_STATS_EN
   ,
   output logic [31:0]   retired_cnt,
   output logic [31:0]   full_stall_cnt
`endif
);

   // Pointers and occupancy
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Per-entry control state
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] done_d;

   // Per-entry payload
   logic [DEPTH-1:0] write_dst_q;
   logic [RW-1:0]    prev_addr_q [DEPTH];

   // Restore bookkeeping
   logic [DEPTH-1:0] flush_mask;   // entries in [restore_tail, tail)
   logic [AW-1:0]    flush_span;   // number of flushed entries
   logic [AW-1:0]    keep_m1;      // surviving entries minus one

   logic alloc_fire;
   logic retire_fire;
   logic complete_hit;

   // -------------------------------------------------------------------------
   // Status and handshakes
   // -------------------------------------------------------------------------
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // No bypass from a same-cycle retirement: a full ROB stays closed for this cycle.
   assign alloc_ready    = ~full & ~restore;
   assign alloc_fire     = alloc_valid & alloc_ready;
   assign alloc_rob_addr = tail_q;

   // Masking with n_rst keeps a retirement from leaking out during a reset cycle.
   assign retire_valid     = n_rst & ~empty & done_q[head_q];
   assign retire_fire      = retire_valid & retire_ready;
   assign retire_write_dst = write_dst_q[head_q];
   assign retire_prev_addr = prev_addr_q[head_q];

   assign rob_head = head_q;
   assign rob_tail = tail_q;
   assign count    = count_q;

   // -------------------------------------------------------------------------
   // Flush range. An entry is younger than the branch when its distance from
   // restore_tail is below the distance from restore_tail to the current tail.
   // If restore_tail equals the tail, the span is zero and nothing is flushed.
   // -------------------------------------------------------------------------
   assign flush_span = tail_q - restore_tail;
   assign keep_m1    = restore_tail - head_q - AW'(1);

   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
      flush_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (AW'(AW'(i) - restore_tail) < flush_span) begin
            flush_mask[i] = 1'b1;
         end
      end
   end

   // A completion to an entry flushed in the same cycle is dropped.
   assign complete_hit = complete_valid & valid_q[complete_rob_addr]
                       & ~(restore & flush_mask[complete_rob_addr]);

   // -------------------------------------------------------------------------
   // Entry valid/done next state. Order matters: completion first, then the
   // retirement clear (covers completing the head while it retires), then the
   // flush, then allocation (never overlaps a live entry).
   // -------------------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      if (complete_hit) begin
         done_d[complete_rob_addr] = 1'b1;
      end
      if (retire_fire) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
      end
      if (restore) begin
         valid_d = valid_d & ~flush_mask;
         done_d  = done_d  & ~flush_mask;
      end
      if (alloc_fire) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
      end
   end

   // The occupancy on restore runs from the head up to restore_tail, wrapping
   // to DEPTH when the two coincide. Any same-cycle retirement is subtracted.
   always_comb begin
      if (restore) begin
         count_d = {1'b0, keep_m1} + CW'(1) - CW'(retire_fire);
      end else begin
         count_d = count_q + CW'(alloc_fire) - CW'(retire_fire);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!n_rst) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         count_q <= count_d;
         if (retire_fire) begin
            head_q <= head_q + AW'(1);
         end
         if (restore) begin
            tail_q <= restore_tail;
         end else if (alloc_fire) begin
            tail_q <= tail_q + AW'(1);
         end
      end
   end

   // NOTE: payload storage has no reset; it is only read under a set valid bit, and the reset-free array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         write_dst_q[tail_q] <= alloc_write_dst;
         prev_addr_q[tail_q] <= alloc_prev_addr;
      end
   end

`ifdef ROB_STATS_EN
   // -------------------------------------------------------------------------
   // Statistics counters. These wrap naturally and are unaffected by restore.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         retired_cnt    <= '0;
         full_stall_cnt <= '0;
      end else begin
         if (retire_fire) begin
            retired_cnt <= retired_cnt + 32'd1;
         end
         if (alloc_valid & full) begin
            full_stall_cnt <= full_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer (DEPTH = 16, D_REG = 64).
//  * A reference model runs on the falling edge. It predicts head, tail,
//    count, flags, handshakes and retire payloads. Allocated payloads are
//    pushed to a queue and popped as they retire.
//  * A table of per-cycle vectors covers the basic allocate/complete/retire
//    flow.
//  * Hand-written sequences cover fill and wrap, restore, simultaneous events,
//    retire back-pressure and mid-stream reset.
//  * The statistics counters are exercised when ROB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   localparam int DEPTH = 16;
   localparam int D_REG = 64;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = $clog2(D_REG);
   localparam int CW    = AW + 1;

   logic          clk;
   logic          n_rst;
   logic          alloc_valid;
   logic          alloc_write_dst;
   logic [RW-1:0] alloc_prev_addr;
   logic          alloc_ready;
   logic [AW-1:0] alloc_rob_addr;
   logic          complete_valid;
   logic [AW-1:0] complete_rob_addr;
   logic          restore;
   logic [AW-1:0] restore_tail;
   logic          retire_valid;
   logic          retire_ready;
   logic          retire_write_dst;
   logic [RW-1:0] retire_prev_addr;
   logic [AW-1:0] rob_head;
   logic [AW-1:0] rob_tail;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
`ifdef ROB_STATS_EN
   logic [31:0]   retired_cnt;
   logic [31:0]   full_stall_cnt;
`endif

   reorder_buffer #(.DEPTH(DEPTH), .D_REG(D_REG)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .alloc_valid       (alloc_valid),
      .alloc_write_dst   (alloc_write_dst),
      .alloc_prev_addr   (alloc_prev_addr),
      .alloc_ready       (alloc_ready),
      .alloc_rob_addr    (alloc_rob_addr),
      .complete_valid    (complete_valid),
      .complete_rob_addr (complete_rob_addr),
      .restore           (restore),
      .restore_tail      (restore_tail),
      .retire_valid      (retire_valid),
      .retire_ready      (retire_ready),
      .retire_write_dst  (retire_write_dst),
      .retire_prev_addr  (retire_prev_addr),
      .rob_head          (rob_head),
      .rob_tail          (rob_tail),
      .count             (count),
      .full              (full),
      .empty             (empty)
`ifdef ROB_STATS_EN
      ,
      .retired_cnt       (retired_cnt),
      .full_stall_cnt    (full_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model and payload scoreboard
   // -------------------------------------------------------------------------
   typedef struct packed {
      logic          wd;
      logic [RW-1:0] pa;
   } pay_t;

   pay_t exp_q[$];
   int   m_head   = 0;
   int   m_tail   = 0;
   int   m_count  = 0;
   bit   m_valid [DEPTH];
   bit   m_done  [DEPTH];
   bit   model_on = 1'b0;

   function automatic int wrap(input int x);
      return ((x % DEPTH) + DEPTH) % DEPTH;
   endfunction

   always @(negedge clk) begin : model
      bit   a_fire;
      bit   r_fire;
      bit   c_ok;
      bit   rv_exp;
      int   span;
      int   keep;
      pay_t p;

      rv_exp = n_rst && (m_count != 0) && m_done[m_head];
      if (model_on) begin
         check("retire_valid", 32'(retire_valid), 32'(rv_exp));
         check("alloc_ready", 32'(alloc_ready), 32'((m_count != DEPTH) && !restore));
         check("alloc_rob_addr", 32'(alloc_rob_addr), m_tail);
         check("rob_head", 32'(rob_head), m_head);
         check("rob_tail", 32'(rob_tail), m_tail);
         check("count", 32'(count), m_count);
         check("full", 32'(full), 32'(m_count == DEPTH));
         check("empty", 32'(empty), 32'(m_count == 0));
         if (rv_exp && exp_q.size() > 0) begin
            check("retire_write_dst", 32'(retire_write_dst), 32'(exp_q[0].wd));
            check("retire_prev_addr", 32'(retire_prev_addr), 32'(exp_q[0].pa));
         end
      end

      if (!n_rst) begin
         m_head  = 0;
         m_tail  = 0;
         m_count = 0;
         for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
         end
         exp_q.delete();
         model_on = 1'b1;
      end else if (model_on) begin
         a_fire = alloc_valid && (m_count != DEPTH) && !restore;
         r_fire = rv_exp && retire_ready;
         span   = wrap(m_tail - int'(restore_tail));
         c_ok   = complete_valid && m_valid[complete_rob_addr]
                  && !(restore && wrap(int'(complete_rob_addr) - int'(restore_tail)) < span);
         if (c_ok) m_done[complete_rob_addr] = 1'b1;
         if (restore) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wrap(i - int'(restore_tail)) < span) begin
                  m_valid[i] = 1'b0;
                  m_done[i]  = 1'b0;
               end
            end
            keep = wrap(int'(restore_tail) - m_head - 1) + 1;
            while (exp_q.size() > keep) void'(exp_q.pop_back());
            m_tail  = restore_tail;
            m_count = keep;
         end else if (a_fire) begin
            p.wd = alloc_write_dst;
            p.pa = alloc_prev_addr;
            exp_q.push_back(p);
            m_valid[m_tail] = 1'b1;
            m_done[m_tail]  = 1'b0;
            m_tail  = wrap(m_tail + 1);
            m_count = m_count + 1;
         end
         if (r_fire) begin
            void'(exp_q.pop_front());
            m_valid[m_head] = 1'b0;
            m_done[m_head]  = 1'b0;
            m_head  = wrap(m_head + 1);
            m_count = m_count - 1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_valid       = 1'b0;
      alloc_write_dst   = 1'b0;
      alloc_prev_addr   = '0;
      complete_valid    = 1'b0;
      complete_rob_addr = '0;
      restore           = 1'b0;
      restore_tail      = '0;
      retire_ready      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   task automatic do_alloc(input int n);
      for (int i = 0; i < n; i++) begin
         alloc_valid     = 1'b1;
         alloc_write_dst = 1'($urandom);
         alloc_prev_addr = RW'($urandom);
         tick();
      end
      alloc_valid = 1'b0;
   endtask

   task automatic do_complete(input int addr);
      complete_valid    = 1'b1;
      complete_rob_addr = AW'(addr);
      tick();
      complete_valid    = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   // Vector table: inputs for one cycle, expected combinational outputs
   // before the edge, and expected state after it.
   // -------------------------------------------------------------------------
   typedef struct packed {
      logic          av;
      logic          wd;
      logic [RW-1:0] pa;
      logic          cv;
      logic [AW-1:0] ca;
      logic          rr;
      logic [AW-1:0] exp_addr;
      logic          exp_rv;
      logic [CW-1:0] exp_count;
      logic [AW-1:0] exp_head;
   } vec_t;

   vec_t vecs [8];

   initial begin
      clear_inputs();
      n_rst = 1'b0;

      // Allocate 0,1,2; complete 1 early; 0 completes later; 0 and 1 retire back to back.
      vecs[0] = '{1'b1, 1'b1, 6'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd1, 4'd0};
      vecs[1] = '{1'b1, 1'b0, 6'd6, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 5'd2, 4'd0};
      vecs[2] = '{1'b1, 1'b1, 6'd7, 1'b1, 4'd1, 1'b0, 4'd2, 1'b0, 5'd3, 4'd0};
      vecs[3] = '{1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 5'd3, 4'd0};
      vecs[4] = '{1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 1'b1, 4'd3, 1'b0, 5'd3, 4'd0};
      vecs[5] = '{1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 5'd2, 4'd1};
      vecs[6] = '{1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 5'd1, 4'd2};
      vecs[7] = '{1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 5'd1, 4'd2};

      // ---- Reset state
      do_reset();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      check("rst_retire_valid", 32'(retire_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);

      // ---- Table-driven basic flow
      for (int i = 0; i < 8; i++) begin
         alloc_valid       = vecs[i].av;
         alloc_write_dst   = vecs[i].wd;
         alloc_prev_addr   = vecs[i].pa;
         complete_valid    = vecs[i].cv;
         complete_rob_addr = vecs[i].ca;
         retire_ready      = vecs[i].rr;
         #1;
         check($sformatf("vec%0d_alloc_rob_addr", i), 32'(alloc_rob_addr), 32'(vecs[i].exp_addr));
         check($sformatf("vec%0d_retire_valid", i), 32'(retire_valid), 32'(vecs[i].exp_rv));
         tick();
         clear_inputs();
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d_rob_head", i), 32'(rob_head), 32'(vecs[i].exp_head));
      end

      // ---- Fill, drop when full, retire with alloc held, tail wrap
      do_reset();
      do_alloc(DEPTH);
      check("fill_full", 32'(full), 32'd1);
      check("fill_alloc_ready", 32'(alloc_ready), 32'd0);
      check("fill_count", 32'(count), 32'd16);
      check("fill_tail_wrap", 32'(rob_tail), 32'd0);
      alloc_valid     = 1'b1;
      alloc_write_dst = 1'b1;
      alloc_prev_addr = 6'd33;
      tick();
      check("drop_count", 32'(count), 32'd16);
      check("drop_tail", 32'(rob_tail), 32'd0);
      do_complete(0);
      alloc_valid  = 1'b1;
      retire_ready = 1'b1;
      #1;
      check("full_retire_valid", 32'(retire_valid), 32'd1);
      check("full_no_bypass", 32'(alloc_ready), 32'd0);
      tick();
      retire_ready = 1'b0;
      check("after_retire_count", 32'(count), 32'd15);
      check("after_retire_head", 32'(rob_head), 32'd1);
      check("after_retire_ready", 32'(alloc_ready), 32'd1);
      check("after_retire_addr", 32'(alloc_rob_addr), 32'd0);
      tick();
      alloc_valid = 1'b0;
      check("refill_count", 32'(count), 32'd16);
      check("refill_tail", 32'(rob_tail), 32'd1);

      // ---- Restore across the wrap point: head 14, tail 4 -> restore_tail 0
      do_reset();
      do_alloc(14);
      for (int i = 0; i < 14; i++) do_complete(i);
      retire_ready = 1'b1;
      repeat (14) tick();
      retire_ready = 1'b0;
      do_alloc(6);
      check("pre_restore_head", 32'(rob_head), 32'd14);
      check("pre_restore_tail", 32'(rob_tail), 32'd4);
      check("pre_restore_count", 32'(count), 32'd6);
      restore           = 1'b1;
      restore_tail      = 4'd0;
      complete_valid    = 1'b1;
      complete_rob_addr = 4'd2;
      #1;
      check("restore_alloc_ready", 32'(alloc_ready), 32'd0);
      tick();
      clear_inputs();
      check("restore_tail", 32'(rob_tail), 32'd0);
      check("restore_count", 32'(count), 32'd2);
      check("restore_head", 32'(rob_head), 32'd14);
      do_complete(14);
      do_complete(15);
      retire_ready = 1'b1;
      tick();
      tick();
      retire_ready = 1'b0;
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_head", 32'(rob_head), 32'd0);
      check("drain_flushed_not_done", 32'(retire_valid), 32'd0);

      // ---- Simultaneous retire, allocate and complete
      do_reset();
      do_alloc(9);
      for (int i = 0; i < 6; i++) do_complete(i);
      retire_ready = 1'b1;
      repeat (5) tick();
      retire_ready = 1'b0;
      check("sim_pre_head", 32'(rob_head), 32'd5);
      check("sim_pre_count", 32'(count), 32'd4);
      alloc_valid       = 1'b1;
      alloc_write_dst   = 1'b1;
      alloc_prev_addr   = 6'd21;
      complete_valid    = 1'b1;
      complete_rob_addr = 4'd7;
      retire_ready      = 1'b1;
      #1;
      check("sim_alloc_addr", 32'(alloc_rob_addr), 32'd9);
      tick();
      clear_inputs();
      check("sim_head", 32'(rob_head), 32'd6);
      check("sim_tail", 32'(rob_tail), 32'd10);
      check("sim_count", 32'(count), 32'd4);
      do_complete(6);
      retire_ready = 1'b1;
      tick();
      check("sim_done7_head", 32'(rob_head), 32'd7);
      check("sim_done7_valid", 32'(retire_valid), 32'd1);
      retire_ready = 1'b0;

      // ---- Retire back-pressure, then mid-stream reset
      do_reset();
      alloc_valid     = 1'b1;
      alloc_write_dst = 1'b1;
      alloc_prev_addr = 6'd42;
      tick();
      alloc_valid = 1'b0;
      do_complete(0);
      for (int i = 0; i < 3; i++) begin
         check("stall_retire_valid", 32'(retire_valid), 32'd1);
         check("stall_head", 32'(rob_head), 32'd0);
         check("stall_count", 32'(count), 32'd1);
         check("stall_prev_addr", 32'(retire_prev_addr), 32'd42);
         tick();
      end
      retire_ready = 1'b1;
      tick();
      retire_ready = 1'b0;
      check("stall_release_count", 32'(count), 32'd0);
      check("stall_release_head", 32'(rob_head), 32'd1);
      do_alloc(2);
      do_complete(1);
      n_rst        = 1'b0;
      retire_ready = 1'b1;
      #1;
      check("midrst_no_retire", 32'(retire_valid), 32'd0);
      tick();
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_count", 32'(count), 32'd0);
      n_rst        = 1'b1;
      retire_ready = 1'b0;

`ifdef ROB_STATS_EN
      // ---- Statistics counters
      do_reset();
      do_alloc(DEPTH);
      alloc_valid = 1'b1;
      tick();
      tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 5; i++) do_complete(i);
      retire_ready = 1'b1;
      repeat (5) tick();
      retire_ready = 1'b0;
      check("stats_retired", retired_cnt, 32'd5);
      check("stats_full_stall", full_stall_cnt, 32'd2);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      check("stats_rst_retired", retired_cnt, 32'd0);
      check("stats_rst_stall", full_stall_cnt, 32'd0);
      check("stats_rst_empty", 32'(empty), 32'd1);
`endif

      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order completion tracker for the out-of-order core.
- Dispatch allocates one entry per instruction at the tail and passes the returned ROB address to the execution buffers.
- Execution writeback marks entries complete.
- Entries retire in program order from the head; retirement releases the previous physical destination register to the free list.
- Supplies rob_head to the execution buffers and accepts checkpoint restores on branch mispredict.

Parameters:
DEPTH, `ROB_SIZE, number of entries; power of two, >= 4
D_REG, `NUM_D_REG, physical data-register count (sets register address width)

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
alloc_valid  in  1  dispatch requests an entry
alloc_write_dst  in  1  instruction writes a data register
alloc_prev_addr  in  $clog2(D_REG)  previous mapping of the destination, freed at retire
alloc_ready  out  1  entry available this cycle
alloc_rob_addr  out  $clog2(DEPTH)  address granted (current tail)
complete_valid  in  1  writeback completes an entry
complete_rob_addr  in  $clog2(DEPTH)  entry being completed
restore  in  1  branch mispredict: roll tail back
restore_tail  in  $clog2(DEPTH)  checkpointed tail (first entry after the branch)
retire_valid  out  1  head entry is complete
retire_ready  in  1  free list accepts the retirement
retire_write_dst  out  1  head entry wrote a register
retire_prev_addr  out  $clog2(D_REG)  register to free
rob_head  out  $clog2(DEPTH)  oldest entry
rob_tail  out  $clog2(DEPTH)  next entry to allocate
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
Per-entry state: valid, done, write_dst, prev_addr. Pointers: head, tail, plus an occupancy counter. All pointers wrap modulo DEPTH.

Reset:
- All valid and done bits cleared; head = tail = 0; count = 0.
- Outputs after reset: empty = 1, full = 0, alloc_ready = 1, retire_valid = 0.

Allocation:
- alloc_ready = ~full & ~restore. It does not depend on a same-cycle retirement (no bypass).
- alloc_rob_addr = tail, combinational.
- On alloc_valid & alloc_ready:
  - entry[tail] is written with valid = 1, done = 0, write_dst, prev_addr.
  - tail is incremented.
- alloc_valid while alloc_ready = 0 is dropped. Dispatch must hold the request.

Completion:
- On complete_valid with entry[complete_rob_addr].valid = 1, done is set at the next clock edge.
- Completion of an invalid entry is ignored.
- Minimum latency from completion to retire_valid is 1 cycle (retire reads the registered done bit).

Retirement:
- retire_valid = ~empty & done[head].
- retire_write_dst and retire_prev_addr come from entry[head]; they are undefined when retire_valid = 0.
- On retire_valid & retire_ready:
  - entry[head].valid and done are cleared.
  - head is incremented.
- One retirement per cycle at most.

Restore:
- The branch entry is guaranteed valid in the ROB when restore is asserted.
- Effects:
  - tail <= restore_tail.
  - Every entry in [restore_tail, old tail) is invalidated.
  - count <= (((restore_tail - head - 1) mod DEPTH) + 1) - retire_fire, giving a range of 0..DEPTH.
- In the restore cycle:
  - Retirement proceeds normally.
  - Completion to a surviving entry is applied.
  - Completion to a flushed entry is dropped.
  - Allocation is blocked.

Count update:
- Without restore: count <= count + alloc_fire - retire_fire.
- Simultaneous alloc and retire leaves count unchanged.

Reset mid-operation: all entries are discarded, with no retirement output in that cycle.

Optional Feature:
ROB_STATS_EN
- Defined: adds output ports retired_cnt [31:0] and full_stall_cnt [31:0].
  - retired_cnt increments on each retire fire.
  - full_stall_cnt increments each cycle that alloc_valid & full.
  - Both counters wrap and clear on reset; restore does not clear them.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then 3 allocations, completing addr 1 only → alloc_rob_addr 0, 1, 2; count = 3; retire_valid stays 0 until addr 0 completes. Then 0 and 1 retire on consecutive cycles; head = 2.
2. Fill DEPTH = 16 → full = 1, alloc_ready = 0, and a 17th alloc_valid is dropped. Complete the head and retire with alloc_valid held → alloc is accepted one cycle later; count returns to 16; tail wraps to 0.
3. head = 14, tail = 4 (count 6), restore with restore_tail = 0 → tail = 0, count = 2; entries 0..3 invalid; a completion to addr 2 in the same cycle is ignored.
4. Same cycle: retire of head 5 with retire_ready = 1, alloc at tail 9, complete addr 7 → head = 6, tail = 10, count unchanged at 4; done[7] = 1 next cycle.
5. retire_ready held 0 for 3 cycles with head complete → retire_valid stays 1 and head, count and retire_prev_addr are stable; retirement occurs in the cycle retire_ready rises.
6. With ROB_STATS_EN: 5 retires and 2 full-stalled allocation cycles → retired_cnt = 5, full_stall_cnt = 2; assert n_rst mid-stream → both 0 and empty = 1 the next cycle.
